// File: rtl/rcc_hsi_div_ctrl.sv
// HSI divider select sequencer.
// Applies software HSIDIV writes to the divider one at a time and holds the ready
// flag low until the new ratio has been held stable for SETTLE_CYC HSI-ready cycles.
// One further write may be queued while a change settles; the last such write wins.
module rcc_hsi_div_ctrl #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned CNT_W      = 5,
    parameter logic [1:0]  RST_DIV    = 2'b00
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_div,
    input  logic       hsi_rdy,
    output logic [1:0] div_sel,
    output logic [1:0] rd_div,
    output logic       div_rdy,
    output logic       busy,
    output logic       pend
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    // Counts down to zero, so the load value is one less than the hold length.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]       state;
    logic [1:0]       tgt;
    logic [1:0]       pend_div;
    logic [CNT_W-1:0] cnt;

    logic             expiry;
    logic             cand_vld;
    logic [1:0]       cand;

    // Settle expiry and the next-change candidate (a write on the expiry edge beats the queue).
    always_comb begin
        expiry   = (state == ST_SETTLE) && (cnt == '0) && hsi_rdy;
        cand_vld = 1'b0;
        cand     = pend_div;
        if (wr_en) begin
            cand_vld = 1'b1;
            cand     = wr_div;
        end else if (pend) begin
            cand_vld = 1'b1;
        end
    end

    // Sequencer state, divider select, settle counter, write queue and status flags.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tgt      <= RST_DIV;
            pend_div <= RST_DIV;
            pend     <= 1'b0;
            cnt      <= '0;
            div_sel  <= RST_DIV;
            rd_div   <= RST_DIV;
            div_rdy  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Readback reflects the last write regardless of sequencing.
            if (wr_en) begin
                rd_div <= wr_div;
            end

            case (state)
                ST_IDLE: begin
                    div_rdy <= hsi_rdy;
                    if (wr_en && (wr_div != div_sel)) begin
                        tgt     <= wr_div;
                        state   <= ST_APPLY;
                        busy    <= 1'b1;
                        div_rdy <= 1'b0;
                    end
                end

                ST_APPLY: begin
                    div_sel <= tgt;
                    cnt     <= CNT_LOAD;
                    state   <= ST_SETTLE;
                    if (wr_en) begin
                        pend     <= 1'b1;
                        pend_div <= wr_div;
                    end
                end

                ST_SETTLE: begin
                    if (expiry) begin
                        pend <= 1'b0;
                        if (cand_vld && (cand != div_sel)) begin
                            tgt   <= cand;
                            state <= ST_APPLY;
                        end else begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            div_rdy <= 1'b1;
                        end
                    end else begin
                        // Counter freezes while HSI is not ready; there is no timeout.
                        if (hsi_rdy && (cnt != '0)) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                        if (wr_en) begin
                            pend     <= 1'b1;
                            pend_div <= wr_div;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    div_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcc_hsi_div_ctrl.sv
// Directed bench for rcc_hsi_div_ctrl with default parameters.
// Edge En is the n-th rising edge after a write sampled at E0; outputs are read 1ns after it.
module tb_rcc_hsi_div_ctrl;

    logic       i_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_div = 2'b00;
    logic       hsi_rdy = 1'b0;
    logic [1:0] div_sel;
    logic [1:0] rd_div;
    logic       div_rdy;
    logic       busy;
    logic       pend;

    int n_checks = 0;
    int n_fail   = 0;

    rcc_hsi_div_ctrl dut (
        .i_clk   (i_clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_div  (wr_div),
        .hsi_rdy (hsi_rdy),
        .div_sel (div_sel),
        .rd_div  (rd_div),
        .div_rdy (div_rdy),
        .busy    (busy),
        .pend    (pend)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Write sampled at the next edge (E0); returns just after E0 with wr_en low.
    task automatic do_write(input logic [1:0] v);
        wr_en  = 1'b1;
        wr_div = v;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hsi_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (div_sel !== 2'b00) begin n_fail++; $display("FAIL rst_div_sel: got %b want 00", div_sel); end
        n_checks++;
        if (rd_div !== 2'b00) begin n_fail++; $display("FAIL rst_rd_div: got %b want 00", rd_div); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++;
        if (pend !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", pend); end
        n_checks++;
        if (div_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_div_rdy_hsi_low: got %b want 0", div_rdy); end
        hsi_rdy = 1'b1;
        tick();
        n_checks++;
        if (div_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_div_rdy_rise: got %b want 1", div_rdy); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_idle: got %b want 0", busy); end
    endtask

    // div_sel 00 -> 10, ready at E17.
    task automatic test_write();
        do_write(2'b10);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_e0_busy: got %b want 1", busy); end
        n_checks++;
        if (div_rdy !== 1'b0) begin n_fail++; $display("FAIL wr_e0_div_rdy: got %b want 0", div_rdy); end
        n_checks++;
        if (rd_div !== 2'b10) begin n_fail++; $display("FAIL wr_e0_rd_div: got %b want 10", rd_div); end
        n_checks++;
        if (div_sel !== 2'b00) begin n_fail++; $display("FAIL wr_e0_div_sel: got %b want 00", div_sel); end
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 1) begin
                n_checks++;
                if (div_sel !== 2'b10) begin n_fail++; $display("FAIL wr_e1_div_sel: got %b want 10", div_sel); end
            end
            if (e == 16) begin
                n_checks++;
                if (div_rdy !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL wr_e16_status: got rdy=%b busy=%b want rdy=0 busy=1", div_rdy, busy);
                end
            end
        end
        n_checks++;
        if (div_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_e17_div_rdy: got %b want 1", div_rdy); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_e17_busy: got %b want 0", busy); end
    endtask

    // div_sel 10 -> 01, then 11 and 10 queued; 10 wins and 11 never appears.
    task automatic test_queue();
        do_write(2'b01);
        for (int e = 1; e <= 34; e++) begin
            if (e == 4) begin wr_en = 1'b1; wr_div = 2'b11; end
            else if (e == 8) begin wr_en = 1'b1; wr_div = 2'b10; end
            else wr_en = 1'b0;
            tick();
            if (div_sel === 2'b11) begin
                n_checks++; n_fail++;
                $display("FAIL q_no_11: got div_sel=%b at E%0d want never 11", div_sel, e);
            end
            if (e == 8) begin
                n_checks++;
                if (pend !== 1'b1) begin n_fail++; $display("FAIL q_pend_set: got %b want 1", pend); end
                n_checks++;
                if (dut.pend_div !== 2'b10) begin n_fail++; $display("FAIL q_pend_div: got %b want 10", dut.pend_div); end
                n_checks++;
                if (rd_div !== 2'b10) begin n_fail++; $display("FAIL q_rd_div: got %b want 10", rd_div); end
            end
            if (e == 17) begin
                n_checks++;
                if (div_sel !== 2'b01) begin n_fail++; $display("FAIL q_e17_div_sel: got %b want 01", div_sel); end
                n_checks++;
                if (pend !== 1'b0 || busy !== 1'b1 || div_rdy !== 1'b0) begin
                    n_fail++; $display("FAIL q_e17_status: got pend=%b busy=%b rdy=%b want 0 1 0", pend, busy, div_rdy);
                end
            end
            if (e == 18) begin
                n_checks++;
                if (div_sel !== 2'b10) begin n_fail++; $display("FAIL q_e18_div_sel: got %b want 10", div_sel); end
            end
            if (e == 33) begin
                n_checks++;
                if (div_rdy !== 1'b0) begin n_fail++; $display("FAIL q_e33_div_rdy: got %b want 0", div_rdy); end
            end
        end
        wr_en = 1'b0;
        n_checks++;
        if (div_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL q_e34_ready: got rdy=%b busy=%b want 1 0", div_rdy, busy);
        end
    endtask

    // div_sel 10 -> 00 with a redundant 00 queued: no second APPLY.
    task automatic test_same_value();
        do_write(2'b00);
        for (int e = 1; e <= 18; e++) begin
            wr_en = (e == 5);
            wr_div = 2'b00;
            tick();
            if (e == 5) begin
                n_checks++;
                if (pend !== 1'b1) begin n_fail++; $display("FAIL same_pend_set: got %b want 1", pend); end
            end
            if (e == 17) begin
                n_checks++;
                if (div_rdy !== 1'b1 || busy !== 1'b0 || pend !== 1'b0) begin
                    n_fail++; $display("FAIL same_e17: got rdy=%b busy=%b pend=%b want 1 0 0", div_rdy, busy, pend);
                end
            end
            if (e == 18) begin
                n_checks++;
                if (busy !== 1'b0 || div_sel !== 2'b00) begin
                    n_fail++; $display("FAIL same_e18_idle: got busy=%b sel=%b want 0 00", busy, div_sel);
                end
            end
        end
        wr_en = 1'b0;
    endtask

    // div_sel 00 -> 11 with hsi_rdy low at edges E6..E10: ready moves to E22.
    task automatic test_hsi_drop();
        do_write(2'b11);
        for (int e = 1; e <= 22; e++) begin
            hsi_rdy = !(e >= 6 && e <= 10);
            tick();
            n_checks++;
            if (div_sel !== 2'b11) begin n_fail++; $display("FAIL drop_div_sel E%0d: got %b want 11", e, div_sel); end
            if (e == 21) begin
                n_checks++;
                if (div_rdy !== 1'b0) begin n_fail++; $display("FAIL drop_e21_div_rdy: got %b want 0", div_rdy); end
            end
        end
        hsi_rdy = 1'b1;
        n_checks++;
        if (div_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_e22_ready: got rdy=%b busy=%b want 1 0", div_rdy, busy);
        end
    endtask

    // div_sel 11 -> 01, then a write of 00 exactly on the expiry edge goes straight to APPLY.
    task automatic test_back_to_back();
        do_write(2'b01);
        for (int e = 1; e <= 34; e++) begin
            wr_en = (e == 17);
            wr_div = 2'b00;
            tick();
            if (e == 17) begin
                n_checks++;
                if (busy !== 1'b1 || div_rdy !== 1'b0 || div_sel !== 2'b01) begin
                    n_fail++; $display("FAIL b2b_e17: got busy=%b rdy=%b sel=%b want 1 0 01", busy, div_rdy, div_sel);
                end
            end
            if (e == 18) begin
                n_checks++;
                if (div_sel !== 2'b00) begin n_fail++; $display("FAIL b2b_e18_div_sel: got %b want 00", div_sel); end
            end
        end
        wr_en = 1'b0;
        n_checks++;
        if (div_rdy !== 1'b1 || rd_div !== 2'b00) begin
            n_fail++; $display("FAIL b2b_e34: got rdy=%b rd=%b want 1 00", div_rdy, rd_div);
        end
    endtask

    // Reset during SETTLE with a queued write discards everything.
    task automatic test_reset_mid();
        do_write(2'b10);
        for (int e = 1; e <= 5; e++) begin
            wr_en = (e == 3);
            wr_div = 2'b01;
            tick();
        end
        wr_en = 1'b0;
        n_checks++;
        if (pend !== 1'b1 || div_sel !== 2'b10) begin
            n_fail++; $display("FAIL rmid_pre: got pend=%b sel=%b want 1 10", pend, div_sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (div_sel !== 2'b00 || rd_div !== 2'b00) begin
            n_fail++; $display("FAIL rmid_sel: got sel=%b rd=%b want 00 00", div_sel, rd_div);
        end
        n_checks++;
        if (pend !== 1'b0 || busy !== 1'b0 || div_rdy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_flags: got pend=%b busy=%b rdy=%b want 0 0 0", pend, busy, div_rdy);
        end
        tick();
        n_checks++;
        if (div_rdy !== 1'b1 || busy !== 1'b0 || div_sel !== 2'b00) begin
            n_fail++; $display("FAIL rmid_after: got rdy=%b busy=%b sel=%b want 1 0 00", div_rdy, busy, div_sel);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_queue();
        test_same_value();
        test_hsi_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
